// File: rtl/serial_cmp_resolver.sv
// Resolves the magnitude relation of two DIGITS*2-bit words from per-digit one-hot
// comparator flags (MSD first), holds the result and counts completed words.
module serial_cmp_resolver #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             F1,
    input  logic             F2,
    input  logic             F3,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             EQ,
    output logic             LT,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned DCW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [DCW-1:0]   dcnt_q;
    logic             decided_q, pend_gt_q;
    logic             ready_q, busy_q, done_q;
    logic             gt_q, eq_q, lt_q, err_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic             onehot;
    logic             last_digit;
    logic             decided_d, pend_gt_d;
    logic [CNT_W-1:0] word_cnt_d;

    always_comb begin
        onehot = 1'b0;
        unique case ({F1, F2, F3})
            3'b100, 3'b010, 3'b001: onehot = 1'b1;
            default:                onehot = 1'b0;
        endcase
        last_digit = (dcnt_q == DCW'(DIGITS - 1));
        // The first non-equal digit (MSD first) fixes the word relation.
        decided_d  = decided_q | F1 | F3;
        pend_gt_d  = decided_q ? pend_gt_q : F1;
        word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dcnt_q     <= '0;
            decided_q  <= 1'b0;
            pend_gt_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        dcnt_q    <= '0;
                        decided_q <= 1'b0;
                        pend_gt_q <= 1'b0;
                        gt_q      <= 1'b0;
                        eq_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        err_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        dcnt_q    <= '0;
                        decided_q <= 1'b0;
                        pend_gt_q <= 1'b0;
                    end else if (in_valid) begin
                        dcnt_q    <= dcnt_q + DCW'(1);
                        decided_q <= decided_d;
                        pend_gt_q <= pend_gt_d;
                        if (!onehot || last_digit) begin
                            state_q    <= S_DONE;
                            ready_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            word_cnt_q <= word_cnt_d;
                            err_q      <= ~onehot;
                            gt_q       <= onehot & decided_d & pend_gt_d;
                            lt_q       <= onehot & decided_d & ~pend_gt_d;
                            eq_q       <= onehot & ~decided_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign GT       = gt_q;
    assign EQ       = eq_q;
    assign LT       = lt_q;
    assign err      = err_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_serial_cmp_resolver.sv
// Randomized bench for serial_cmp_resolver: words are built from random 2-bit digit
// values and the expected relation comes from comparing the whole words as integers.
module tb_serial_cmp_resolver;

    localparam int unsigned DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, in_valid = 1'b0, F1 = 1'b0, F2 = 1'b0, F3 = 1'b0;

    logic       in_ready, busy, done, GT, EQ, LT, err;
    logic [7:0] word_cnt;
    logic       in_ready2, busy2, done2, GT2, EQ2, LT2, err2;
    logic [1:0] word_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int words    = 0;

    logic [2:0] wflags [DIGITS];

    serial_cmp_resolver #(.DIGITS(DIGITS), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .F1(F1), .F2(F2), .F3(F3), .in_ready(in_ready), .busy(busy), .done(done),
        .GT(GT), .EQ(EQ), .LT(LT), .err(err), .word_cnt(word_cnt)
    );

    serial_cmp_resolver #(.DIGITS(DIGITS), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .F1(F1), .F2(F2), .F3(F3), .in_ready(in_ready2), .busy(busy2), .done(done2),
        .GT(GT2), .EQ(EQ2), .LT(LT2), .err(err2), .word_cnt(word_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] res_bits(input int code);
        case (code)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_main"}, 32'({in_ready, busy, done, GT, EQ, LT, err, word_cnt}), 32'd0);
        check({tag, "_sat"}, 32'({in_ready2, busy2, done2, GT2, EQ2, LT2, err2, word_cnt2}), 32'd0);
    endtask

    // code: 0 GT, 1 EQ, 2 LT, 3 err; n_acc: digits the DUT should consume.
    task automatic run_word(input int code, input int n_acc, input int gmin, input int gmax,
                            input bit restart);
        int c8, c2;
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        check("start_state", 32'({busy, in_ready, done}), 32'b110);
        check("start_clear", 32'({GT, EQ, LT, err}), 32'd0);
        if (restart) begin
            for (int i = 0; i < 2; i++) begin
                in_valid = 1'b1; {F1, F2, F3} = 3'b100;
                step();
                check("pre_restart", 32'({busy, in_ready, done}), 32'b110);
            end
            start = 1'b1; in_valid = 1'b1; {F1, F2, F3} = 3'b001;
            step();
            start = 1'b0; in_valid = 1'b0;
            check("restart_state", 32'({busy, in_ready, done}), 32'b110);
            check("restart_clear", 32'({GT, EQ, LT, err}), 32'd0);
        end
        for (int i = 0; i < n_acc; i++) begin
            int g = int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0; {F1, F2, F3} = 3'($urandom);
                step();
                check("gap_hold", 32'({busy, in_ready, done}), 32'b110);
            end
            in_valid = 1'b1; {F1, F2, F3} = wflags[i];
            step();
            in_valid = 1'b0;
            if (i < n_acc - 1)
                check("mid_word", 32'({busy, in_ready, done}), 32'b110);
        end
        words++;
        c8 = (words > 255) ? 255 : words;
        c2 = (words > 3) ? 3 : words;
        check("done_pulse", 32'({busy, in_ready, done}), 32'b001);
        check("result", 32'({GT, EQ, LT, err}), 32'(res_bits(code)));
        check("cnt8", 32'(word_cnt), 32'(c8));
        check("sat_done", 32'({GT2, EQ2, LT2, err2, busy2, in_ready2, done2}),
              32'({res_bits(code), 3'b001}));
        check("cnt2", 32'(word_cnt2), 32'(c2));
        start = 1'($urandom);
        step();
        start = 1'b0;
        check("idle_after", 32'({busy, in_ready, done}), 32'b000);
        check("result_held", 32'({GT, EQ, LT, err}), 32'(res_bits(code)));
    endtask

    task automatic random_word(input int gmax, input bit restart);
        logic [2:0] bad [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        int A = 0, B = 0, code, n_acc, p;
        for (int i = 0; i < DIGITS; i++) begin
            int a = int'($urandom_range(3, 0));
            int b = ($urandom_range(2, 0) == 0) ? a : int'($urandom_range(3, 0));
            A = A * 4 + a;
            B = B * 4 + b;
            wflags[i] = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
        end
        code  = (A > B) ? 0 : (A == B) ? 1 : 2;
        n_acc = DIGITS;
        if ($urandom_range(4, 0) == 0) begin
            p = int'($urandom_range(DIGITS - 1, 0));
            wflags[p] = bad[$urandom_range(4, 0)];
            code  = 3;
            n_acc = p + 1;
        end
        run_word(code, n_acc, 0, gmax, restart);
    endtask

    initial begin
        #12;
        check_all_zero("reset_init");
        rst = 1'b0;
        step();

        wflags = '{3'b010, 3'b100, 3'b001, 3'b001};
        run_word(0, 4, 0, 0, 1'b0);

        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        words = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        #2 rst = 1'b0;
        step();
        check("start_in_reset", 32'({busy, in_ready, done}), 32'b000);

        wflags = '{3'b010, 3'b010, 3'b010, 3'b010};
        run_word(1, 4, 1, 1, 1'b0);

        wflags = '{3'b010, 3'b101, 3'b100, 3'b100};
        run_word(3, 2, 0, 0, 1'b0);

        wflags = '{3'b001, 3'b001, 3'b001, 3'b001};
        run_word(2, 4, 0, 0, 1'b1);

        for (int w = 0; w < 40; w++)
            random_word(w % 3, ($urandom_range(3, 0) == 0));

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; {F1, F2, F3} = 3'b010;
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_word");
        words = 0;
        #2 rst = 1'b0;
        step();
        check("after_mid_reset", 32'({busy, in_ready, done, done2}), 32'd0);

        wflags = '{3'b100, 3'b001, 3'b001, 3'b001};
        run_word(0, 4, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
